// File: rtl/natv_axil_bridge_pkg.sv
// Shared definitions for the native-bus to AXI4-Lite bridge.
package natv_axil_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Width of the per-access timeout counter; one spare bit above the terminal count.
    function automatic int tmo_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

endpackage

// File: rtl/natv_axil_bridge_tmo_cnt.sv
// Per-access timeout counter plus saturating count of timeout events.
module axil_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       evt_i,
    output logic       tc_o,
    output logic [7:0] evt_cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count stays asserted once reached, so a late response cannot skip past it.
    assign tc_o = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Access-age counter: held at zero while idle, stops at terminal count.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && !tc_o)
            cnt_q <= cnt_q + 1'b1;
    end

    // Timeout event counter, saturating at 255.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            evt_cnt_o <= '0;
        else if (evt_i && (evt_cnt_o != 8'hFF))
            evt_cnt_o <= evt_cnt_o + 8'd1;
    end

endmodule

// File: rtl/natv_axil_bridge.sv
// Native valid/ready core bus to AXI4-Lite master, one access in flight, with timeout retirement.
module natv_axil_bridge
    import natv_axil_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        tmo_irq_o,
    output logic [7:0]  tmo_cnt_o
);

    localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic        ready_q, tmo_irq_q;
    logic        tmo_fire, tc;

    axil_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == ST_IDLE),
        .en_i      ((state_q != ST_IDLE) && (state_q != ST_DONE)),
        .evt_i     (tmo_fire),
        .tc_o      (tc),
        .evt_cnt_o (tmo_cnt_o)
    );

    // Next state, handshake tracking and completion data; a real response beats the timeout.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = '0;
        tmo_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (mem_valid_i)
                    state_d = (|mem_wstrb_i) ? ST_WR_ADDR : ST_RD_ADDR;
            end
            ST_WR_ADDR: begin
                aw_done_d = aw_done_q | (awvalid_q & mem_axi_awready);
                w_done_d  = w_done_q  | (wvalid_q  & mem_axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end else if (tc) begin
                    state_d  = ST_DONE;
                    tmo_fire = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (mem_axi_bvalid) begin
                    state_d = ST_DONE;
                end else if (tc) begin
                    state_d  = ST_DONE;
                    tmo_fire = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (mem_axi_arready) begin
                    state_d = ST_RD_DATA;
                end else if (tc) begin
                    state_d  = ST_DONE;
                    rdata_d  = ERR_RDATA;
                    tmo_fire = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (mem_axi_rvalid) begin
                    state_d = ST_DONE;
                    rdata_d = mem_axi_rdata;
                end else if (tc) begin
                    state_d  = ST_DONE;
                    rdata_d  = ERR_RDATA;
                    tmo_fire = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request capture and registered bus outputs derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            tmo_irq_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (state_q == ST_IDLE && mem_valid_i) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                wstrb_q <= mem_wstrb_i;
                instr_q <= mem_instr_i;
            end
            awvalid_q <= (state_d == ST_WR_ADDR) && !aw_done_d;
            wvalid_q  <= (state_d == ST_WR_ADDR) && !w_done_d;
            bready_q  <= (state_d == ST_IDLE) || (state_d == ST_WR_RESP);
            arvalid_q <= (state_d == ST_RD_ADDR);
            rready_q  <= (state_d == ST_IDLE) || (state_d == ST_RD_DATA);
            ready_q   <= (state_d == ST_DONE);
            tmo_irq_q <= tmo_fire;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_ready_o     = ready_q;
    assign mem_rdata_o     = rdata_q;
    assign tmo_irq_o       = tmo_irq_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = addr_q;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = addr_q;
    assign mem_axi_arprot  = {instr_q, 2'b00};
    assign mem_axi_rready  = rready_q;

endmodule
